popcount_stream: RTL and testbench

//  Sequential, parametrised population counter: accepts one WIDTH-bit word per

---
 rtl/popcount_stream.sv | 120 ++++++++++++
 tb/tb_popcount_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_stream.sv
// Sequential popcount: one WIDTH-bit word per valid/ready transaction,
// counted CHUNK bits per cycle, result held until the consumer takes it.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_data word, in_zeros selects
//                       counting clear bits instead of set bits
//   out_valid/out_ready output handshake; out_count is the result
//   busy                high while chunks are being counted
// Optional: define POPCOUNT_THRESH_EN to add the thresh input and the out_ge
// output (out_count >= thresh latched with the word).
module popcount_stream #(
    parameter int WIDTH  = 255,
    parameter int CHUNK  = 32,
    parameter int CNT_W  = $clog2(WIDTH + 1),
    parameter int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_zeros,
`ifdef POPCOUNT_THRESH_EN
    input  logic [CNT_W-1:0] thresh,
    output logic             out_ge,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int PW    = NCHUNK * CHUNK;
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    word;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] sum;
    logic             accept;
`ifdef POPCOUNT_THRESH_EN
    logic [CNT_W-1:0] thr;
`endif

    function automatic logic [CNT_W-1:0] ones(input logic [CHUNK-1:0] w);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++)
            c = c + CNT_W'(w[i]);
        return c;
    endfunction

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == COUNT);
    // The word is shifted down each cycle, so the current chunk is always
    // the low CHUNK bits.
    assign sum      = acc + ones(word[CHUNK-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
`ifdef POPCOUNT_THRESH_EN
            thr       <= '0;
            out_ge    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                // Invert before zero-extension so padding bits stay 0
                // and never count, whichever polarity is requested.
                word  <= PW'(in_data ^ {WIDTH{in_zeros}});
                acc   <= '0;
                idx   <= '0;
`ifdef POPCOUNT_THRESH_EN
                thr   <= thresh;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (accept)
                        state <= COUNT;
                end
                COUNT: begin
                    acc  <= sum;
                    word <= word >> CHUNK;
                    idx  <= idx + 1'b1;
                    if (idx == LAST) begin
                        out_count <= sum;
                        out_valid <= 1'b1;
`ifdef POPCOUNT_THRESH_EN
                        out_ge    <= (sum >= thr);
`endif
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef POPCOUNT_THRESH_EN
                        out_ge    <= 1'b0;
`endif
                        state     <= in_valid ? COUNT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_stream.sv
// Self-checking bench for popcount_stream: vector table, scoreboard queue,
// and hand sequences for stall, back-to-back and mid-count reset.
module tb_popcount_stream;

    localparam int W  = 255;
    localparam int CW = 8;
    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_zeros;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          busy;
`ifdef POPCOUNT_THRESH_EN
    logic          m_ge;
    logic          t_valid, t_ready, t_zeros, t_ovalid, t_oready, t_busy, t_ge;
    logic [15:0]   t_data;
    logic [4:0]    t_thresh, t_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [CW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]  data;
        logic          zeros;
        logic [CW-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    popcount_stream dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_zeros(in_zeros),
`ifdef POPCOUNT_THRESH_EN
        .thresh(8'd0), .out_ge(m_ge),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .busy(busy)
    );

`ifdef POPCOUNT_THRESH_EN
    popcount_stream #(.WIDTH(16), .CHUNK(5)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(t_valid), .in_ready(t_ready),
        .in_data(t_data), .in_zeros(t_zeros),
        .thresh(t_thresh), .out_ge(t_ge),
        .out_valid(t_ovalid), .out_ready(t_oready),
        .out_count(t_count), .busy(t_busy)
    );
`endif

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Drive one word from IDLE; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic z,
                        input logic [CW-1:0] e);
        @(negedge clk);
        in_data  = d;
        in_zeros = z;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        in_valid = 1'b0;
        in_data  = {8{$urandom}};
        in_zeros = ~z;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        logic [CW-1:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("out_count", 32'(out_count), 32'(e));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 0);
    endtask

    initial begin
        int lat;
        logic [CW-1:0] held;
        logic [W-1:0] r;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_zeros  = 1'b0;
        out_ready = 1'b0;
`ifdef POPCOUNT_THRESH_EN
        t_valid  = 1'b0;
        t_data   = '0;
        t_zeros  = 1'b0;
        t_thresh = '0;
        t_oready = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        vecs[0] = '{{W{1'b1}}, 1'b0, 8'd255};
        vecs[1] = '{'0, 1'b1, 8'd255};
        vecs[2] = '{255'h1, 1'b0, 8'd1};
        vecs[3] = '{255'h1 << 254, 1'b0, 8'd1};
        vecs[4] = '{'0, 1'b0, 8'd0};
        vecs[5] = '{{W{1'b1}}, 1'b1, 8'd0};
        vecs[6] = '{255'h1 << 224, 1'b1, 8'd254};
        for (int i = 7; i < 10; i++) begin
            r = {8{$urandom}};
            vecs[i] = '{r, i[0], i[0] ? 8'(W - $countones(r))
                                      : 8'($countones(r))};
        end

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].data, vecs[i].zeros, vecs[i].exp);
            check("busy_count", 32'(busy), 1);
            wait_result(lat);
            check("latency", 32'(lat), NC);
            take();
        end

        // Stall in DONE: result held, new words refused.
        send({W{1'b1}} >> 100, 1'b0, 8'd155);
        wait_result(lat);
        held = out_count;
        in_valid = 1'b1;
        in_data  = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid), 1);
            check("stall_count", 32'(out_count), 32'(held));
            check("stall_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        take();
        check("stall_no_queue", 32'(busy), 0);

        // Back-to-back: accept next word on the same edge as the result.
        send(255'hF, 1'b0, 8'd4);
        wait_result(lat);
        in_valid  = 1'b1;
        in_data   = 255'hFF;
        in_zeros  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 1);
        check("b2b_count0", 32'(out_count), 32'(exp_q.pop_front()));
        exp_q.push_back(8'd8);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        wait_result(lat);
        check("b2b_spacing", 32'(lat + 1), NC + 1);
        take();

        // Reset on the third COUNT cycle drops the word.
        send({W{1'b1}}, 1'b0, 8'd255);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_count", 32'(out_count), 0);
        check("mid_rst_busy", 32'(busy), 0);
        send(255'h5 << 200, 1'b0, 8'd2);
        wait_result(lat);
        check("post_rst_latency", 32'(lat), NC);
        take();

`ifdef POPCOUNT_THRESH_EN
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            t_data   = 16'hF0F0;
            t_thresh = k[0] ? 5'd9 : 5'd8;
            t_valid  = 1'b1;
            @(posedge clk);
            #1;
            t_valid = 1'b0;
            lat = 0;
            while (!t_ovalid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("thr_latency", 32'(lat), 4);
            check("thr_count", 32'(t_count), 8);
            check("thr_ge", 32'(t_ge), k[0] ? 0 : 1);
            t_oready = 1'b1;
            @(posedge clk);
            #1;
            t_oready = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1 required 0");
        $fatal(1);
    end

endmodule
